bp_pht_ctrl: RTL and testbench

// - Sequencer for the single-port pattern history table (PHT) of 3-bit saturating counters in the fetch-stage branch predictor.
// - Forms the gshare index (pc_idx ^ ghr), serves fetch lookups and queues resolved-branch updates.
// - Drains queued updates as read-modify-write cycles in slots left free by lookups.
// - Initialises the table after reset by sweeping every entry.

---
 rtl/bp_pht_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bp_pht_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: gshare PHT sequencer (init sweep, lookups, queued RMW updates).
// Optional macro GHR_SPEC_EN selects speculative history with mispredict repair.
module bp_pht_ctrl #(
  parameter int         IDX_W    = 10,
  parameter int         Q_DEPTH  = 4,
  parameter logic [2:0] INIT_VAL = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_pc_idx,
  output logic             lk_ready,
  output logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic             res_mispred,
  input  logic [IDX_W-1:0] res_ghr,
  output logic             res_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [2:0]       tbl_wdata,
  input  logic [2:0]       tbl_rdata,
  output logic [IDX_W-1:0] ghr,
  output logic             busy
);
  localparam int QW = $clog2(Q_DEPTH);
  localparam logic [QW:0] Q_FULL = (QW+1)'(Q_DEPTH);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_UPD_RD, S_UPD_CAP, S_UPD_WR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W-1:0] r_q_idx [Q_DEPTH];
  logic             r_q_tkn [Q_DEPTH];
  logic [QW-1:0]    r_wp;
  logic [QW-1:0]    r_rp;
  logic [QW:0]      r_cnt;
  logic [2:0]       r_ctr;
  logic             r_pv;
  logic             w_lk;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [IDX_W-1:0] w_head;
  logic             w_head_tkn;
  logic [2:0]       w_new;

  assign w_full     = (r_cnt == Q_FULL);
  assign lk_ready   = !rst && (r_state != S_INIT);
  assign w_lk       = lk_valid && lk_ready;
  assign lk_idx     = lk_pc_idx ^ r_ghr;
  assign res_ready  = rst || !w_full;
  assign w_push     = res_valid && !w_full;
  assign w_pop      = (r_state == S_UPD_WR) && !w_lk;
  assign w_head     = r_q_idx[r_rp];
  assign w_head_tkn = r_q_tkn[r_rp];
  assign pred_valid = r_pv;
  assign pred_taken = r_pv & tbl_rdata[2];
  assign ghr        = r_ghr;
  assign busy       = (r_state == S_INIT) || (r_cnt != '0);

  always_comb begin
    w_new = r_ctr;
    if (w_head_tkn) begin
      if (r_ctr != 3'd7) w_new = r_ctr + 3'd1;
    end else begin
      if (r_ctr != 3'd0) w_new = r_ctr - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:    if (r_ptr == '1) w_next = S_IDLE;
      S_IDLE:    if (r_cnt != '0) w_next = S_UPD_RD;
      S_UPD_RD:  if (!w_lk) w_next = S_UPD_CAP;
      S_UPD_CAP: w_next = S_UPD_WR;
      S_UPD_WR:  if (!w_lk) w_next = S_IDLE;
      default:   w_next = S_INIT;
    endcase
  end

  // Lookups always win the single port; update steps stall behind them.
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = lk_idx;
    tbl_wdata = INIT_VAL;
    if (!rst) begin
      if (w_lk) begin
        tbl_en = 1'b1;
      end else begin
        unique case (r_state)
          S_INIT: begin
            tbl_en   = 1'b1;
            tbl_we   = 1'b1;
            tbl_addr = r_ptr;
          end
          S_UPD_RD: begin
            tbl_en   = 1'b1;
            tbl_addr = w_head;
          end
          S_UPD_WR: begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = w_head;
            tbl_wdata = w_new;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wp] <= res_idx;
      r_q_tkn[r_wp] <= res_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_pv  <= 1'b0;
      r_ctr <= '0;
    end else begin
      r_pv <= w_lk;
      if (r_state == S_INIT)    r_ptr <= r_ptr + 1'b1;
      if (r_state == S_UPD_CAP) r_ctr <= tbl_rdata;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef GHR_SPEC_EN
  // Mispredict repair overrides a same-cycle speculative shift.
  always_ff @(posedge clk) begin
    if (rst)
      r_ghr <= '0;
    else if (w_push && res_mispred)
      r_ghr <= {res_ghr[IDX_W-2:0], res_taken};
    else if (r_pv)
      r_ghr <= {r_ghr[IDX_W-2:0], tbl_rdata[2]};
  end
`else
  logic w_unused;
  assign w_unused = ^{res_mispred, res_ghr};

  always_ff @(posedge clk) begin
    if (rst)
      r_ghr <= '0;
    else if (w_push)
      r_ghr <= {r_ghr[IDX_W-2:0], res_taken};
  end
`endif

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// tb_bp_pht_ctrl: directed and random checks of bp_pht_ctrl against a
// table/history reference model with a bench-side PHT memory.
module tb_bp_pht_ctrl;
  localparam int IDX_W = 10;
  localparam int N = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             lk_valid;
  logic [IDX_W-1:0] lk_pc_idx;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_idx;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic             res_taken;
  logic             res_mispred;
  logic [IDX_W-1:0] res_ghr;
  logic             res_ready;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [2:0]       tbl_wdata;
  logic [2:0]       tbl_rdata;
  logic [IDX_W-1:0] ghr;
  logic             busy;

  logic [2:0] mem [N];
  int n_wr = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [IDX_W-1:0] m_ghr;
  logic m_pv;
  logic m_pred;
  int m_init;
  int ref_pht [N];

  bp_pht_ctrl #(.IDX_W(IDX_W), .Q_DEPTH(4), .INIT_VAL(3'b100)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc_idx(lk_pc_idx),
    .lk_ready(lk_ready), .lk_idx(lk_idx),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_idx(res_idx),
    .res_taken(res_taken), .res_mispred(res_mispred),
    .res_ghr(res_ghr), .res_ready(res_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata), .ghr(ghr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) begin
        mem[tbl_addr] <= tbl_wdata;
        n_wr <= n_wr + 1;
      end else begin
        tbl_rdata <= mem[tbl_addr];
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(int v, logic t);
    if (t) return (v == 7) ? 7 : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic tick();
    logic acc_lk;
    logic acc_res;
    logic nxt;
    logic [IDX_W-1:0] li;
    #1;
    li = lk_pc_idx ^ m_ghr;
    acc_lk = !rst && m_init == 0 && lk_valid;
    acc_res = !rst && res_valid && res_ready;
    if (rst) begin
      check("rst_tbl_en", tbl_en, 0);
      check("rst_lk_ready", lk_ready, 0);
    end else begin
      check("lk_ready", lk_ready, m_init == 0);
      check("ghr", ghr, m_ghr);
      check("pred_valid", pred_valid, m_pv);
      if (m_pv) check("pred_taken", pred_taken, m_pred);
      if (m_init != 0)
        check("init_wr", {tbl_en, tbl_we, tbl_addr, tbl_wdata},
              {2'b11, IDX_W'(N - m_init), 3'b100});
    end
    if (acc_lk) begin
      check("lk_idx", lk_idx, li);
      check("lk_rd", {tbl_en, tbl_we, tbl_addr}, {2'b10, li});
    end
    nxt = (mem[li] >= 3'd4);
    if (acc_res) ref_pht[res_idx] = sat(ref_pht[res_idx], res_taken);
    if (rst) begin
      m_ghr = '0;
      m_init = N;
      for (int i = 0; i < N; i++) ref_pht[i] = 4;
    end else begin
`ifdef GHR_SPEC_EN
      if (acc_res && res_mispred) m_ghr = {res_ghr[IDX_W-2:0], res_taken};
      else if (m_pv) m_ghr = {m_ghr[IDX_W-2:0], m_pred};
`else
      if (acc_res) m_ghr = {m_ghr[IDX_W-2:0], res_taken};
`endif
      if (m_init != 0) m_init--;
    end
    m_pv = acc_lk;
    m_pred = nxt;
    @(negedge clk);
  endtask

  task automatic push(logic [IDX_W-1:0] idx, logic tk);
    res_valid = 1'b1;
    res_idx = idx;
    res_taken = tk;
    res_mispred = 1'b0;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    int k = 0;
    while (busy && k < 64) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic lookup(logic [IDX_W-1:0] idx);
    lk_valid = 1'b1;
    lk_pc_idx = idx ^ m_ghr;
    tick();
    lk_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int w0;
    logic [2:0] old;
    rst = 1'b1;
    lk_valid = 1'b0;
    lk_pc_idx = '0;
    res_valid = 1'b0;
    res_idx = '0;
    res_taken = 1'b0;
    res_mispred = 1'b0;
    res_ghr = '0;
    m_ghr = '0;
    m_pv = 1'b0;
    m_pred = 1'b0;
    m_init = N;
    for (int i = 0; i < N; i++) ref_pht[i] = 4;
    @(negedge clk);
    tick();
    #1;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_tbl_we", tbl_we, 0);
    check("rst_res_ready", res_ready, 1);
    check("rst_ghr", ghr, 0);
    rst = 1'b0;
    #1;
    check("init_busy", busy, 1);
    repeat (N) tick();
    check("boot_busy", busy, 0);
    check("boot_lk_ready", lk_ready, 1);

    lookup(10'h005);
    #1;
    check("pred5_hi", {pred_valid, pred_taken}, 2'b11);
    tick();

    push(10'h005, 1'b0);
    k = 0;
    #1;
    while (!(tbl_en && tbl_we) && k < 10) begin
      tick();
      k++;
      #1;
    end
    check("upd_lat", k, 3);
    check("upd_wr", {tbl_addr, tbl_wdata}, {10'h005, 3'b011});
    tick();
    check("upd_busy", busy, 0);
    lookup(10'h005);
    #1;
    check("pred5_lo", {pred_valid, pred_taken}, 2'b10);
    tick();

    repeat (8) begin
      push(10'h010, 1'b1);
      drain("sat_up");
    end
    check("sat_hi", mem[16], 7);
    repeat (8) begin
      push(10'h010, 1'b0);
      drain("sat_dn");
    end
    check("sat_lo", mem[16], 0);

    w0 = n_wr;
    lk_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lk_pc_idx = IDX_W'($urandom);
      res_valid = 1'b1;
      res_idx = IDX_W'(32'h100 + i);
      res_taken = i[0];
      res_mispred = 1'b0;
      #1;
      check("q_ready", res_ready, i < 4);
      tick();
    end
    res_valid = 1'b0;
    lk_pc_idx = IDX_W'($urandom);
    tick();
    check("q_stall", n_wr - w0, 0);
    lk_valid = 1'b0;
    drain("q_full");
    check("q_writes", n_wr - w0, 4);
    check("q_ready_end", res_ready, 1);
    check("q_drop", mem[10'h104], 4);

    old = mem[10'h020];
    push(10'h020, 1'b1);
    push(10'h021, 1'b0);
    k = 0;
    #1;
    while (!(tbl_en && tbl_we) && k < 20) begin
      tick();
      k++;
      #1;
    end
    check("mid_wr_addr", {tbl_en, tbl_we, tbl_addr}, {2'b11, 10'h020});
    rst = 1'b1;
    tick();
    check("mid_nowr", mem[10'h020], old);
    rst = 1'b0;
    repeat (N) tick();
    check("mid_flush", busy, 0);
    check("mid_ready", res_ready, 1);

    repeat (600) begin
      lk_valid = ($urandom_range(0, 1) == 1);
      lk_pc_idx = IDX_W'($urandom);
      res_valid = ($urandom_range(0, 3) == 0);
      res_idx = IDX_W'($urandom_range(0, 15));
      res_taken = ($urandom_range(0, 1) == 1);
      res_mispred = ($urandom_range(0, 3) == 0);
      res_ghr = IDX_W'($urandom);
      tick();
    end
    lk_valid = 1'b0;
    res_valid = 1'b0;
    drain("rnd");
    for (int i = 0; i < N; i++)
      check($sformatf("tbl[%0d]", i), mem[i], ref_pht[i]);
    lookup(10'h003);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
